imem_responder: RTL and testbench

- Instruction-memory responder: the target end of the fetch interface that the PC/fetch logic drives.
- Accepts one fetch address per valid/ready handshake, reads a word-addressed instruction array, and returns the instruction after a fixed latency on a valid/ready response channel.
- A side load port fills the array from the testbench or boot logic.
- Sits between the PC unit and decode in the single-cycle/multicycle core bring-up flow.

---
 rtl/imem_responder.sv | 130 +++++++++++++
 tb/tb_imem_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, response after LATENCY cycles.
// Optional fetch/error handshake counters are enabled by defining IMEM_FETCH_STATS_EN.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  output logic [1:0]                     state_dbg
`ifdef IMEM_FETCH_STATS_EN
  ,
  output logic [31:0]                    fetch_count,
  output logic [15:0]                    err_count
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and response payload holds while rsp_valid & !rsp_ready.
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  RELOAD    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam state_t ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            accept;
  logic            req_err;
  logic [AW-1:0]   req_idx;

  assign req_idx   = req_addr[AW+1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = ACC_STATE;
          cnt_n   = RELOAD;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = RESP;
          cnt_n   = 4'd0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (accept) begin
            state_n = ACC_STATE;
            cnt_n   = RELOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The read samples the array before this edge's load lands, so a same-word load is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_instr <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_err   <= req_err;
      rsp_instr <= req_err ? NOP_INSTR : mem[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

`ifdef IMEM_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= 32'd0;
      err_count   <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      fetch_count <= fetch_count + 32'd1;
      if (rsp_err) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=2 and a LATENCY=1 instance share the load bus;
// a word-array model predicts each response, which a monitor checks at presentation.
module tb_imem_responder;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_instr [2];
  logic        rsp_err   [2];
  logic [1:0]  state_dbg [2];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
`ifdef IMEM_FETCH_STATS_EN
  logic [31:0] fetch_count [2];
  logic [15:0] err_count   [2];
`endif

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
    .rsp_err(rsp_err[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .state_dbg(state_dbg[0])
`ifdef IMEM_FETCH_STATS_EN
    , .fetch_count(fetch_count[0]), .err_count(err_count[0])
`endif
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
    .rsp_err(rsp_err[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .state_dbg(state_dbg[1])
`ifdef IMEM_FETCH_STATS_EN
    , .fetch_count(fetch_count[1]), .err_count(err_count[1])
`endif
  );

  // Expected entry: {dut index, err, instr}; t_q holds the accept edge number.
  logic [33:0] exp_q[$];
  int          t_q[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          presented [2];
  int          hs_cnt [2];
  int          err_hs [2];
  int          rr_mode [2];
  int          last_acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // rsp_ready policy per instance: 0 always ready, 1 random, 2 stalled.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rr_mode[d])
        0:       rsp_ready[d] = 1'b1;
        1:       rsp_ready[d] = 1'($urandom_range(0, 1));
        default: rsp_ready[d] = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (exp_q.size() == 0 || exp_q[0][33] != 1'(d)) begin
            chk($sformatf("spurious_rsp%0d", d), 32'd1, 32'd0);
          end else begin
            chk($sformatf("rsp_instr%0d", d), rsp_instr[d], exp_q[0][31:0]);
            chk($sformatf("rsp_err%0d", d), {31'd0, rsp_err[d]}, {31'd0, exp_q[0][32]});
            chk($sformatf("req_ready_in_resp%0d", d), {31'd0, req_ready[d]}, {31'd0, rsp_ready[d]});
            if (!presented[d]) begin
              chk($sformatf("latency%0d", d), cyc - t_q[0], (d == 0) ? 32'd1 : 32'd0);
              presented[d] = 1'b1;
            end
            if (rsp_ready[d]) begin
              hs_cnt[d]++;
              if (exp_q[0][32]) err_hs[d]++;
              void'(exp_q.pop_front());
              void'(t_q.pop_front());
              presented[d] = 1'b0;
            end
          end
        end else if (exp_q.size() > 0 && exp_q[0][33] == 1'(d) &&
                     (cyc - t_q[0]) > ((d == 0) ? 1 : 0)) begin
          chk($sformatf("late_or_dropped_rsp%0d", d), 32'd0, 32'd1);
          void'(exp_q.pop_front());
          void'(t_q.pop_front());
          presented[d] = 1'b0;
        end
      end
    end
  end

  task automatic load(input logic [7:0] i, input logic [31:0] dat);
    ld_en = 1'b1;
    ld_addr = i;
    ld_data = dat;
    mem_m[i] = dat;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, input bit do_ld,
                       input logic [7:0] li, input logic [31:0] ldat);
    bit done = 1'b0;
    bit e;
    logic [31:0] word;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        e = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        word = e ? NOP : mem_m[addr[9:2]];
        exp_q.push_back({1'(d), e, word});
        t_q.push_back(cyc + 1);
        last_acc = cyc + 1;
        if (do_ld) begin
          ld_en = 1'b1;
          ld_addr = li;
          ld_data = ldat;
          mem_m[li] = ldat;
        end
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    ld_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      t_q.delete();
      presented[0] = 1'b0;
      presented[1] = 1'b0;
    end
  endtask

  task automatic rand_fetches(input int d, input int n);
    int r;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 1) a = 32'h400 + {$urandom_range(0, 4095), 2'b00};
      else             a = {22'd0, 8'($urandom), 2'b00};
      fetch(d, a, 1'b0, 8'd0, 32'd0);
      if ($urandom_range(0, 3) == 0) load(a[9:2], $urandom);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'd0;
      rsp_ready[d] = 1'b1;
      rr_mode[d]   = 0;
      hs_cnt[d]    = 0;
      err_hs[d]    = 0;
      presented[d] = 1'b0;
    end
    ld_en = 1'b0;
    ld_addr = 8'd0;
    ld_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("reset_rsp_instr", rsp_instr[d], 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
      chk("reset_state", {30'd0, state_dbg[d]}, 32'd0);
    end

    for (int i = 0; i < DEPTH; i++) load(8'(i), $urandom);
    load(8'd0, 32'h0050_0093);
    load(8'd1, 32'h00A0_0113);
    load(8'd2, NOP);

    // Directed fetches, including misaligned and just-out-of-range addresses.
    fetch(0, 32'h0, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h4, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h2, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h400, 1'b0, 8'd0, 32'd0);
    drain();

    // Stall the response five cycles, then release it with a request already waiting.
    rr_mode[0] = 2;
    fetch(0, 32'h0, 1'b0, 8'd0, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
    chk("stall_req_ready", {31'd0, req_ready[0]}, 32'd0);
    rr_mode[0] = 0;
    fetch(0, 32'h4, 1'b0, 8'd0, 32'd0);
    drain();

    // Same-edge load and fetch of word 2 returns the old word; the next fetch sees the new one.
    fetch(0, 32'h8, 1'b1, 8'd2, 32'hDEAD_BEEF);
    fetch(0, 32'h8, 1'b0, 8'd0, 32'd0);
    drain();

    rr_mode[0] = 1;
    rand_fetches(0, 40);
    drain();

    // Reset while the response is still pending.
    rr_mode[0] = 0;
    fetch(0, 32'h0, 1'b0, 8'd0, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("midrst_state", {30'd0, state_dbg[0]}, 32'd0);
    chk("midrst_rsp_instr", rsp_instr[0], 32'd0);
    exp_q.delete();
    t_q.delete();
    presented[0] = 1'b0;
    hs_cnt[0] = 0;
    err_hs[0] = 0;
    hs_cnt[1] = 0;
    err_hs[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fetch(0, 32'h0, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h4, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h8, 1'b0, 8'd0, 32'd0);
    fetch(0, 32'h2, 1'b0, 8'd0, 32'd0);
    drain();
    @(posedge clk);
    #1;
`ifdef IMEM_FETCH_STATS_EN
    chk("fetch_count_after_4", fetch_count[0], 32'd4);
    chk("err_count_after_4", {16'd0, err_count[0]}, 32'd1);
`endif

    // LATENCY=1 instance: back-to-back stream must be accepted on consecutive edges.
    fetch(1, 32'h0, 1'b0, 8'd0, 32'd0);
    begin
      int prev;
      prev = last_acc;
      fetch(1, 32'h4, 1'b0, 8'd0, 32'd0);
      chk("stream_gap1", last_acc - prev, 32'd1);
      prev = last_acc;
      fetch(1, 32'h8, 1'b0, 8'd0, 32'd0);
      chk("stream_gap2", last_acc - prev, 32'd1);
    end
    drain();
    rr_mode[1] = 1;
    rand_fetches(1, 30);
    drain();
    @(posedge clk);
    #1;
`ifdef IMEM_FETCH_STATS_EN
    for (int d = 0; d < 2; d++) begin
      chk("fetch_count_final", fetch_count[d], 32'(hs_cnt[d]));
      chk("err_count_final", {16'd0, err_count[d]}, 32'(err_hs[d]));
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
